// File: rtl/ctrl_pkg.sv
// Shared opcode, ALU-select and state definitions for the multi-cycle control unit.
package ctrl_pkg;

  localparam logic [3:0] OP_JMP   = 4'd7;
  localparam logic [3:0] OP_LOAD  = 4'd11;
  localparam logic [3:0] OP_STORE = 4'd12;
  localparam logic [3:0] OP_BEQ   = 4'd13;
  localparam logic [3:0] OP_BNE   = 4'd14;
  localparam logic [3:0] OP_NOP   = 4'd15;

  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, FAULT} state_t;

  typedef enum logic [2:0] {
    CLS_REG, CLS_IMM, CLS_LOAD, CLS_STORE, CLS_BEQ, CLS_BNE, CLS_JMP, CLS_NOP
  } class_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: instruction class plus the static EXEC-state controls.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int ALU_CS_W = 3
) (
  input  logic [3:0]          op,
  output class_t              cls,
  output logic [ALU_CS_W-1:0] alucs,
  output logic                flagwrite,
  output logic                selscrB,
  output logic                redges
);

  always_comb begin
    cls       = CLS_NOP;
    alucs     = '0;
    flagwrite = 1'b0;
    selscrB   = 1'b0;
    redges    = 1'b0;
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
        cls       = CLS_REG;
        redges    = 1'b1;
        alucs     = ALU_CS_W'(op[2:0]);
        flagwrite = (op == 4'd2) || (op == 4'd3) || (op == 4'd5) || (op == 4'd6);
      end
      4'd8, 4'd9, 4'd10: begin
        cls       = CLS_IMM;
        selscrB   = 1'b1;
        alucs     = ALU_CS_W'(op[2:0]);
        flagwrite = op[1];
      end
      OP_LOAD, OP_STORE: begin
        cls       = (op == OP_LOAD) ? CLS_LOAD : CLS_STORE;
        selscrB   = 1'b1;
        alucs     = ALU_CS_W'(ALU_ADD);
        flagwrite = 1'b1;
      end
      OP_BEQ: begin
        cls   = CLS_BEQ;
        alucs = ALU_CS_W'(ALU_SUB);
      end
      OP_BNE: begin
        cls   = CLS_BNE;
        alucs = ALU_CS_W'(ALU_SUB);
      end
      OP_JMP: begin
        cls   = CLS_JMP;
        alucs = ALU_CS_W'(ALU_ADD);
      end
      default: cls = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory with handshaked
// memories, a per-request timeout that traps into FAULT, and a retired-instruction counter.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int ALU_CS_W  = 3,
  parameter int TIMEOUT   = 255,
  parameter int INSTRET_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [3:0]           op,
  input  logic                 zero,
  input  logic                 imem_ack,
  input  logic                 dmem_ack,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 regwrite,
  output logic                 selscrB,
  output logic                 redges,
  output logic                 memtoreg,
  output logic                 wren,
  output logic                 flagwrite,
  output logic                 branch,
  output logic                 jump,
  output logic [ALU_CS_W-1:0]  alucs,
  output logic                 mem_err,
  output logic [INSTRET_W-1:0] instret
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t              state, state_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
  logic                ireq_hold, hold_nxt;
  logic                retire;

  class_t              dec_cls;
  logic [ALU_CS_W-1:0] dec_alucs;
  logic                dec_flagwrite, dec_selscrB, dec_redges;

  ctrl_decode #(.ALU_CS_W(ALU_CS_W)) u_decode (
    .op        (op),
    .cls       (dec_cls),
    .alucs     (dec_alucs),
    .flagwrite (dec_flagwrite),
    .selscrB   (dec_selscrB),
    .redges    (dec_redges)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      wait_cnt  <= '0;
      ireq_hold <= 1'b0;
      instret   <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      ireq_hold <= hold_nxt;
      if (retire)
        instret <= instret + INSTRET_W'(1);
    end
  end

  assign mem_err = (state == FAULT);

  // An unacknowledged fetch stays requested via ireq_hold even if run drops.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    hold_nxt  = 1'b0;
    retire    = 1'b0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    regwrite  = 1'b0;
    selscrB   = 1'b0;
    redges    = 1'b0;
    memtoreg  = 1'b0;
    wren      = 1'b0;
    flagwrite = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    alucs     = '0;
    case (state)
      FETCH: begin
        imem_req = run | ireq_hold;
        if (imem_req) begin
          if (imem_ack) begin
            ir_write  = 1'b1;
            state_nxt = DECODE;
            wait_nxt  = '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state_nxt = FAULT;
          end else begin
            wait_nxt = wait_cnt + WAIT_W'(1);
            hold_nxt = 1'b1;
          end
        end
      end
      DECODE: state_nxt = EXEC;
      EXEC: begin
        alucs     = dec_alucs;
        flagwrite = dec_flagwrite;
        selscrB   = dec_selscrB;
        redges    = dec_redges;
        wait_nxt  = '0;
        if (dec_cls == CLS_LOAD || dec_cls == CLS_STORE) begin
          state_nxt = MEM;
        end else begin
          regwrite  = (dec_cls == CLS_REG) || (dec_cls == CLS_IMM);
          branch    = ((dec_cls == CLS_BEQ) && zero) || ((dec_cls == CLS_BNE) && !zero);
          jump      = (dec_cls == CLS_JMP);
          pc_write  = 1'b1;
          retire    = 1'b1;
          state_nxt = FETCH;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        selscrB  = 1'b1;
        alucs    = ALU_CS_W'(ALU_ADD);
        wren     = (dec_cls == CLS_STORE);
        if (dmem_ack) begin
          regwrite  = (dec_cls == CLS_LOAD);
          memtoreg  = (dec_cls == CLS_LOAD);
          pc_write  = 1'b1;
          retire    = 1'b1;
          wait_nxt  = '0;
          state_nxt = FETCH;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = FAULT;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      FAULT: state_nxt = FAULT;
      default: state_nxt = FETCH;
    endcase
  end

endmodule
